// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared definitions for the BPSK demodulator slice.
//   - default SAMPLE_NUMBER / SAMPLE_WIDTH / DATA_WIDTH
//   - MIDSCALE constant and offset-binary to two's-complement conversion
//   - accumulator width derivation
//   - symbol-sync state encoding
package bpsk_pkg;

  localparam int unsigned DEF_SAMPLE_NUMBER = 256;
  localparam int unsigned DEF_SAMPLE_WIDTH  = 12;
  localparam int unsigned DEF_DATA_WIDTH    = 12;

  localparam int unsigned MIDSCALE = 1 << (DEF_SAMPLE_WIDTH - 1);

  typedef enum logic {
    SYNC_HUNT,
    SYNC_LOCKED
  } sync_state_t;

  function automatic int unsigned midscale(input int unsigned w);
    return 1 << (w - 1);
  endfunction

  // Subtracting midscale is the same as inverting the MSB of a w-bit
  // offset-binary code and reading the result as two's complement.
  function automatic int ob_to_signed(input int unsigned x, input int unsigned w);
    return int'(x) - int'(midscale(w));
  endfunction

  // Product of two w-bit signed values summed over sn samples cannot overflow.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned sn);
    return 2 * w + $clog2(sn);
  endfunction

endpackage

// File: rtl/bpsk_demodulator_correlator.sv
// bpsk_correlator: per-symbol correlation of the received stream against the
// sine reference, with a sign decision at the end of each symbol.
//   clk, rst_n   clock, asynchronous active-low reset
//   valid_in     sample accepted this cycle
//   signal_in    received sample (offset binary)
//   sine_in      reference sample (offset binary)
//   last_in      sample is the final one of its symbol
//   dec_valid    one-cycle pulse per decision
//   dec_bit      decided bit (1 when correlation >= 0)
//   dec_metric   |correlation| slice (only with BPSK_DEMOD_METRIC_EN)
module bpsk_correlator
  import bpsk_pkg::*;
#(
  parameter int unsigned SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
  parameter int unsigned SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [SAMPLE_WIDTH-1:0] signal_in,
  input  logic [SAMPLE_WIDTH-1:0] sine_in,
  input  logic                    last_in,
  output logic                    dec_valid,
  output logic                    dec_bit
`ifdef BPSK_DEMOD_METRIC_EN
  ,output logic [15:0]            dec_metric
`endif
);

  localparam int unsigned PW    = 2 * SAMPLE_WIDTH;
  localparam int unsigned ACC_W = acc_width(SAMPLE_WIDTH, SAMPLE_NUMBER);

  logic signed [SAMPLE_WIDTH-1:0] sig_s;
  logic signed [SAMPLE_WIDTH-1:0] ref_s;
  logic signed [PW-1:0]           prod_d;
  logic signed [PW-1:0]           prod_q;
  logic                           last_q;
  logic                           vld_q;
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        sum;

  always_comb begin
    sig_s  = SAMPLE_WIDTH'(ob_to_signed(32'(signal_in), SAMPLE_WIDTH));
    ref_s  = SAMPLE_WIDTH'(ob_to_signed(32'(sine_in), SAMPLE_WIDTH));
    prod_d = PW'(sig_s) * PW'(ref_s);
    sum    = acc + ACC_W'(prod_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q     <= '0;
      last_q     <= 1'b0;
      vld_q      <= 1'b0;
      acc        <= '0;
      dec_valid  <= 1'b0;
      dec_bit    <= 1'b0;
`ifdef BPSK_DEMOD_METRIC_EN
      dec_metric <= '0;
`endif
    end else begin
      // Stage 1: product register; a held-off cycle still lets stage 2 drain.
      vld_q <= valid_in;
      if (valid_in) begin
        prod_q <= prod_d;
        last_q <= last_in;
      end
      // Stage 2: accumulate, decide and clear on the symbol's last product.
      dec_valid <= 1'b0;
      if (vld_q) begin
        if (last_q) begin
          acc       <= '0;
          dec_valid <= 1'b1;
          dec_bit   <= ~sum[ACC_W-1];
`ifdef BPSK_DEMOD_METRIC_EN
          // Truncating after the shift keeps bits [ACC_W-2 -: 16] of |sum|.
          dec_metric <= 16'(((sum < 0) ? -sum : sum) >>> (ACC_W - 17));
`endif
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: rtl/bpsk_demodulator.sv
// bpsk_demodulator: coherent BPSK demodulator. Correlates each symbol period
// against the shared sine reference, decides one bit per symbol and
// reassembles DATA_WIDTH-bit words MSB first.
//   clk, rst_n   clock, asynchronous active-low reset
//   en           sample-valid qualifier
//   signal_in    received sample, offset binary
//   sine_in      reference sine sample, offset binary
//   cnt_in       phase index of the current sample
//   bit_out      last decided bit;  bit_valid  pulse per bit
//   data_out     last full word;    data_valid pulse per word
//   metric_out   per-symbol confidence, present only when the macro
//                BPSK_DEMOD_METRIC_EN is defined
module bpsk_demodulator
  import bpsk_pkg::*;
#(
  parameter int unsigned SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
  parameter int unsigned SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [SAMPLE_WIDTH-1:0]          signal_in,
  input  logic [SAMPLE_WIDTH-1:0]          sine_in,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_in,
  output logic                             bit_out,
  output logic                             bit_valid,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_valid
`ifdef BPSK_DEMOD_METRIC_EN
  ,output logic [15:0]                     metric_out
`endif
);

  localparam int unsigned CW  = $clog2(SAMPLE_NUMBER);
  localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  sync_state_t             sync_state;
  logic                    sample_ok;
  logic                    last_sample;
  logic                    dec_valid;
  logic                    dec_bit;
  logic [BCW-1:0]          bit_cnt;
  logic [DATA_WIDTH-2:0]   shreg;
  logic [DATA_WIDTH-1:0]   word_next;
`ifdef BPSK_DEMOD_METRIC_EN
  logic [15:0]             dec_metric;
`endif

  // The sample that locks symbol sync is itself accumulated.
  always_comb begin
    sample_ok   = en && ((sync_state == SYNC_LOCKED) || (cnt_in == '0));
    last_sample = (cnt_in == CW'(SAMPLE_NUMBER - 1));
    word_next   = {shreg, dec_bit};
  end

  bpsk_correlator #(
    .SAMPLE_NUMBER (SAMPLE_NUMBER),
    .SAMPLE_WIDTH  (SAMPLE_WIDTH)
  ) u_correlator (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (sample_ok),
    .signal_in  (signal_in),
    .sine_in    (sine_in),
    .last_in    (last_sample),
    .dec_valid  (dec_valid),
    .dec_bit    (dec_bit)
`ifdef BPSK_DEMOD_METRIC_EN
    ,.dec_metric (dec_metric)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_state <= SYNC_HUNT;
      bit_cnt    <= '0;
      shreg      <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
`ifdef BPSK_DEMOD_METRIC_EN
      metric_out <= '0;
`endif
    end else begin
      if (en && (cnt_in == '0))
        sync_state <= SYNC_LOCKED;

      bit_valid  <= dec_valid;
      data_valid <= 1'b0;
      if (dec_valid) begin
        bit_out <= dec_bit;
        shreg   <= word_next[DATA_WIDTH-2:0];
`ifdef BPSK_DEMOD_METRIC_EN
        metric_out <= dec_metric;
`endif
        if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
          bit_cnt    <= '0;
          data_out   <= word_next;
          data_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + BCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Directed testbench for bpsk_demodulator. Inputs are driven on the falling
// edge; outputs are observed on the falling edge by a monitor process.
module tb_bpsk_demodulator;
  import bpsk_pkg::*;

  localparam int SN = 256;
  localparam int SW = 12;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [SW-1:0] signal_in;
  logic [SW-1:0] sine_in;
  logic [7:0]    cnt_in;
  logic          bit_out;
  logic          bit_valid;
  logic [DW-1:0] data_out;
  logic          data_valid;
`ifdef BPSK_DEMOD_METRIC_EN
  logic [15:0]   metric_out;
`endif

  bpsk_demodulator #(
    .SAMPLE_NUMBER (SN),
    .SAMPLE_WIDTH  (SW),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .signal_in  (signal_in),
    .sine_in    (sine_in),
    .cnt_in     (cnt_in),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .data_out   (data_out),
    .data_valid (data_valid)
`ifdef BPSK_DEMOD_METRIC_EN
    ,.metric_out (metric_out)
`endif
  );

  always #5 clk = ~clk;

  int sine_rom [SN];
  int tests = 0;
  int fails = 0;

  // Edge bookkeeping: cyc is the index of the most recent rising edge.
  int cyc = 0;
  int last_edge = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en && cnt_in == 8'(SN - 1)) last_edge <= cyc + 1;
  end

  // Output monitor.
  int          nbits = 0;
  int          ndv = 0;
  int          dv_cyc = 0;
  int          lat = 0;
  int          nmzero = 0;
  logic [63:0] bit_hist = '0;
  always @(negedge clk) begin
    if (bit_valid) begin
      nbits    <= nbits + 1;
      bit_hist <= {bit_hist[62:0], bit_out};
      lat      <= cyc - last_edge;
`ifdef BPSK_DEMOD_METRIC_EN
      if (metric_out == 16'd0) nmzero <= nmzero + 1;
`endif
    end
    if (data_valid) begin
      ndv    <= ndv + 1;
      dv_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input int sig, input int c);
    @(negedge clk);
    en        = e;
    signal_in = SW'(sig);
    sine_in   = SW'(sine_rom[c]);
    cnt_in    = 8'(c);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, int'(MIDSCALE), 0);
    @(negedge clk);
    #1;
  endtask

  // mode 0: modulated word, 1: constant midscale, 2: negated sine throughout
  function automatic int sample_for(input int mode, input logic b, input int c);
    case (mode)
      0:       return b ? sine_rom[c] : 4096 - sine_rom[c];
      1:       return int'(MIDSCALE);
      default: return 4096 - sine_rom[c];
    endcase
  endfunction

  task automatic send_word(input logic [DW-1:0] word, input int mode,
                           input int gap_sym, input int gap_at);
    for (int s = 0; s < DW; s++) begin
      for (int c = 0; c < SN; c++) begin
        if (s == gap_sym && c == gap_at)
          repeat (10) drive(1'b0, sample_for(mode, word[DW-1-s], c), c);
        drive(1'b1, sample_for(mode, word[DW-1-s], c), c);
      end
    end
  endtask

  int b0, d0, m0, t0, base_delay;

  initial begin
    for (int i = 0; i < SN; i++)
      sine_rom[i] = 2048 + int'(2047.0 * $sin(2.0 * 3.14159265358979 * i / 256.0));

    rst_n     = 1'b0;
    en        = 1'b0;
    signal_in = SW'(MIDSCALE);
    sine_in   = SW'(MIDSCALE);
    cnt_in    = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_bit_out", 32'(bit_out), 0);
    check("rst_bit_valid", 32'(bit_valid), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_data_valid", 32'(data_valid), 0);
`ifdef BPSK_DEMOD_METRIC_EN
    check("rst_metric", 32'(metric_out), 0);
`endif
    rst_n = 1'b1;

    // Late start: partial symbol from cnt 100 must not produce a decision.
    b0 = nbits;
    for (int c = 100; c < SN; c++) drive(1'b1, sine_rom[c], c);
    idle(4);
    check("late_no_bits", 32'(nbits - b0), 0);

    // Loopback of 12'hA5C, right after the late start.
    b0 = nbits; d0 = ndv; t0 = cyc;
    send_word(12'hA5C, 0, -1, 0);
    idle(4);
    check("loop_nbits", 32'(nbits - b0), 12);
    check("loop_bit_seq", 32'(bit_hist[11:0]), 32'h A5C);
    check("loop_ndv", 32'(ndv - d0), 1);
    check("loop_data", 32'(data_out), 32'h A5C);
    check("loop_latency", 32'(lat), 2);
    base_delay = dv_cyc - t0;

    // Constant midscale: every correlation ties at zero, deciding 1.
    b0 = nbits; d0 = ndv;
    send_word(12'h000, 1, -1, 0);
    idle(4);
    check("mid_ndv", 32'(ndv - d0), 1);
    check("mid_data", 32'(data_out), 32'h FFF);

    // Negated sine: every bit decides 0 with a nonzero confidence.
    b0 = nbits; d0 = ndv; m0 = nmzero;
    send_word(12'hFFF, 2, -1, 0);
    idle(4);
    check("inv_nbits", 32'(nbits - b0), 12);
    check("inv_data", 32'(data_out), 32'h000);
`ifdef BPSK_DEMOD_METRIC_EN
    check("inv_metric_zero_cnt", 32'(nmzero - m0), 0);
`endif

    // en dropped for 10 cycles mid-symbol with cnt held.
    d0 = ndv; t0 = cyc;
    send_word(12'hA5C, 0, 3, 100);
    idle(4);
    check("gap_ndv", 32'(ndv - d0), 1);
    check("gap_data", 32'(data_out), 32'h A5C);
    check("gap_delay", 32'(dv_cyc - t0), 32'(base_delay + 10));

    // Reset after 5 bits of an all-ones word, partway into the sixth symbol.
    b0 = nbits;
    for (int s = 0; s < 5; s++)
      for (int c = 0; c < SN; c++) drive(1'b1, sine_rom[c], c);
    for (int c = 0; c < 50; c++) drive(1'b1, sine_rom[c], c);
    #1;
    check("pre_rst_nbits", 32'(nbits - b0), 5);
    check("pre_rst_bit_out", 32'(bit_out), 1);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bit_out", 32'(bit_out), 0);
    check("mid_rst_data_out", 32'(data_out), 0);
    check("mid_rst_bit_valid", 32'(bit_valid), 0);
    check("mid_rst_data_valid", 32'(data_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b0 = nbits; d0 = ndv;
    send_word(12'h5A3, 0, -1, 0);
    idle(4);
    check("post_rst_nbits", 32'(nbits - b0), 12);
    check("post_rst_ndv", 32'(ndv - d0), 1);
    check("post_rst_data", 32'(data_out), 32'h 5A3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
